// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with signed overflow detection plus iterative unsigned
// multiply (shift-add) and divide (restoring), one bit per clock, behind a
// start/busy/done handshake. Single-cycle ops finish on the accept edge.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    // Counter loads WIDTH and stops at 1, so it never wraps or underflows.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH-1:0] opnd;    // multiplicand for mul, divisor for div
    logic [WIDTH-1:0] wk_hi;   // partial product high half / partial remainder
    logic [WIDTH-1:0] wk_lo;   // multiplier being consumed / dividend-quotient

    logic accept;
    logic iter_op;
    logic last_iter;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] dif;

    logic             sc_upd;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_try;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // Signed overflow of x + y giving r: like-signed operands, result sign flipped.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y giving r: unlike-signed operands, result sign differs from x.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign sa        = a;
    assign sb        = b;
    assign sum       = sa + sb;
    assign dif       = sa - sb;
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign iter_op   = (ALUcontrol == OP_MUL) || (ALUcontrol == OP_DIV);
    assign last_iter = (state == S_RUN) && (cnt == CNT_ONE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    // Single-cycle result; sc_upd is low for no-op codes so results are kept.
    always_comb begin
        sc_upd = 1'b0;
        sc_lo  = '0;
        sc_ovf = 1'b0;
        case (ALUcontrol)
            OP_ADD: begin
                sc_upd = 1'b1;
                sc_lo  = sum;
                sc_ovf = add_ovf(sa, sb, sum);
            end
            OP_SUB: begin
                sc_upd = 1'b1;
                sc_lo  = dif;
                sc_ovf = sub_ovf(sa, sb, dif);
            end
            OP_AND: begin
                sc_upd = 1'b1;
                sc_lo  = a & b;
            end
            OP_OR: begin
                sc_upd = 1'b1;
                sc_lo  = a | b;
            end
            OP_SLT: begin
                sc_upd = 1'b1;
                sc_lo  = {{(WIDTH-1){1'b0}}, (sa < sb)};
            end
            default: begin
                sc_upd = 1'b0;
            end
        endcase
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], wk_lo[WIDTH-1:1]};

        rem_sh  = {wk_hi, wk_lo[WIDTH-1]};
        rem_try = rem_sh - {1'b0, opnd};
        if (!rem_try[WIDTH]) begin
            div_hi = rem_try[WIDTH-1:0];
            div_lo = {wk_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = rem_sh[WIDTH-1:0];
            div_lo = {wk_lo[WIDTH-2:0], 1'b0};
        end

        nxt_hi = is_div ? div_hi : mul_hi;
        nxt_lo = is_div ? div_lo : mul_lo;
    end

    // Control FSM, iteration counter and working registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            opnd   <= '0;
            wk_hi  <= '0;
            wk_lo  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept && iter_op) begin
                        state  <= S_RUN;
                        cnt    <= CNT_INIT;
                        is_div <= (ALUcontrol == OP_DIV);
                        opnd   <= (ALUcontrol == OP_DIV) ? b : a;
                        wk_hi  <= '0;
                        wk_lo  <= (ALUcontrol == OP_DIV) ? a : b;
                    end else if (accept) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    wk_hi <= nxt_hi;
                    wk_lo <= nxt_lo;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Result and flag registers; written only at a completion edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_lo <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else if (accept && !iter_op) begin
            div_zero <= 1'b0;
            if (sc_upd) begin
                result_lo <= sc_lo;
                result_hi <= '0;
                zero      <= (sc_lo == '0);
                overflow  <= sc_ovf;
            end
        end else if (last_iter) begin
            result_lo <= nxt_lo;
            result_hi <= nxt_hi;
            zero      <= (nxt_lo == '0);
            overflow  <= 1'b0;
            div_zero  <= is_div && (opnd == '0);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a 32-bit and an 8-bit instance, directed cases plus
// random operations; expected results queued at issue, checked on done.
module tb_seq_alu;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_J   = 4'b1111;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        int          lat;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        logic        bsy;
        logic        dn;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, rst1, st0, st1;
    logic [3:0]  ctl0, ctl1;
    logic [31:0] a0, b0;
    logic [7:0]  a1, b1;
    logic [31:0] lo0, hi0;
    logic [7:0]  lo1, hi1;
    logic        zf0, of0, dz0, bs0, dn0;
    logic        zf1, of1, dz1, bs1, dn1;

    seq_alu #(.WIDTH(32), .CNT_W(6)) u32 (
        .clk(clk), .reset(rst0), .start(st0), .ALUcontrol(ctl0), .a(a0), .b(b0),
        .result_lo(lo0), .result_hi(hi0), .zero(zf0), .overflow(of0),
        .div_zero(dz0), .busy(bs0), .done(dn0)
    );

    seq_alu #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk(clk), .reset(rst1), .start(st1), .ALUcontrol(ctl1), .a(a1), .b(b1),
        .result_lo(lo1), .result_hi(hi1), .zero(zf1), .overflow(of1),
        .div_zero(dz1), .busy(bs1), .done(dn1)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t last[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic out_t rd(input int d);
        out_t o;
        if (d == 0) begin
            o.lo = lo0; o.hi = hi0; o.z = zf0; o.ov = of0; o.dz = dz0; o.bsy = bs0; o.dn = dn0;
        end else begin
            o.lo = {24'b0, lo1}; o.hi = {24'b0, hi1}; o.z = zf1; o.ov = of1; o.dz = dz1;
            o.bsy = bs1; o.dn = dn1;
        end
        return o;
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e.lo = '0; e.hi = '0; e.z = 1'b0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 0; e.cyc = 0;
        return e;
    endfunction

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input int d, input logic [3:0] op,
                                   input logic [31:0] av, input logic [31:0] bv);
        int          w;
        logic [63:0] mask, p;
        longint      sa, sb, r, smax, smin;
        exp_t        e;
        w    = (d == 0) ? 32 : 8;
        mask = (64'd1 << w) - 64'd1;
        sa   = av[w-1] ? longint'({32'b0, av}) - (longint'(1) << w) : longint'({32'b0, av});
        sb   = bv[w-1] ? longint'({32'b0, bv}) - (longint'(1) << w) : longint'({32'b0, bv});
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        e     = last[d];
        e.lat = 0;
        e.dz  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r    = (op == OP_ADD) ? sa + sb : sa - sb;
                e.lo = 32'(r) & 32'(mask);
                e.hi = '0;
                e.ov = (r > smax) || (r < smin);
                e.z  = (e.lo == 0);
            end
            OP_AND, OP_OR, OP_SLT: begin
                if (op == OP_AND)     e.lo = av & bv;
                else if (op == OP_OR) e.lo = av | bv;
                else                  e.lo = (sa < sb) ? 32'd1 : 32'd0;
                e.hi = '0;
                e.ov = 1'b0;
                e.z  = (e.lo == 0);
            end
            OP_MUL: begin
                p     = {32'b0, av} * {32'b0, bv};
                e.lo  = 32'(p & mask);
                e.hi  = 32'((p >> w) & mask);
                e.ov  = 1'b0;
                e.z   = (e.lo == 0);
                e.lat = w;
            end
            OP_DIV: begin
                if (bv == 0) begin
                    e.lo = 32'(mask);
                    e.hi = av;
                    e.dz = 1'b1;
                end else begin
                    e.lo = av / bv;
                    e.hi = av % bv;
                end
                e.ov  = 1'b0;
                e.z   = (e.lo == 0);
                e.lat = w;
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    task automatic drv(input int d, input logic s, input logic [3:0] op,
                       input logic [31:0] av, input logic [31:0] bv);
        if (d == 0) begin
            st0 = s; ctl0 = op; a0 = av; b0 = bv;
        end else begin
            st1 = s; ctl1 = op; a1 = av[7:0]; b1 = bv[7:0];
        end
    endtask

    task automatic set_start(input int d, input logic s);
        if (d == 0) st0 = s;
        else        st1 = s;
    endtask

    // Drive a request, wait for the accept edge, queue the expected completion.
    task automatic issue(input int d, input logic [3:0] op,
                         input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] am, bm;
        exp_t        e;
        am = (d == 0) ? av : {24'b0, av[7:0]};
        bm = (d == 0) ? bv : {24'b0, bv[7:0]};
        drv(d, 1'b1, op, am, bm);
        @(posedge clk);
        #1;
        e     = model(d, op, am, bm);
        e.cyc = cyc + e.lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        last[d] = e;
    endtask

    // Issue one op and wait (bounded) for done; poke>=0 pulses start mid-run.
    task automatic run_op(input int d, input logic [3:0] op,
                          input logic [31:0] av, input logic [31:0] bv, input int poke);
        exp_t prev;
        out_t o;
        int   bcnt;
        logic got;
        prev = last[d];
        issue(d, op, av, bv);
        @(negedge clk);
        set_start(d, 1'b0);
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            o = rd(d);
            if (o.dn) begin
                got = 1'b1;
            end else begin
                if (o.bsy) begin
                    bcnt++;
                    chk("hold_lo", o.lo, prev.lo);
                    chk("hold_hi", o.hi, prev.hi);
                end
                if (i == poke)          drv(d, 1'b1, OP_ADD, 32'd1, 32'd1);
                else if (i == poke + 1) set_start(d, 1'b0);
                @(negedge clk);
            end
        end
        set_start(d, 1'b0);
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_cycles", 32'(bcnt), 32'(last[d].lat));
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued entry.
    always @(negedge clk) begin : mon
        out_t o;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            o = rd(d);
            if (o.dn) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("result_lo", o.lo, e.lo);
                    chk("result_hi", o.hi, e.hi);
                    chk("zero", 32'(o.z), 32'(e.z));
                    chk("overflow", 32'(o.ov), 32'(e.ov));
                    chk("div_zero", 32'(o.dz), 32'(e.dz));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_at_done", 32'(o.bsy), 32'd0);
                end
            end
        end
    end

    task automatic chk_cleared(input int d, input string tag);
        out_t o;
        o = rd(d);
        chk({tag, "_lo"}, o.lo, 32'd0);
        chk({tag, "_hi"}, o.hi, 32'd0);
        chk({tag, "_flags"}, {27'd0, o.z, o.ov, o.dz, o.bsy, o.dn}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd(input int d);
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 20);
            1: v = $urandom;
            2: begin
                case ($urandom_range(0, 3))
                    0: v = 32'd0;
                    1: v = (d == 0) ? 32'hFFFF_FFFF : 32'hFF;
                    2: v = (d == 0) ? 32'h8000_0000 : 32'h80;
                    default: v = (d == 0) ? 32'h7FFF_FFFF : 32'h7F;
                endcase
            end
            default: v = $urandom & 32'h0000_FFFF;
        endcase
        return v;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] tbl [9];
        logic [3:0] op;
        int         k;
        tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_J, 4'b0011};
        last[0] = zero_e();
        last[1] = zero_e();
        rst0 = 1'b1; rst1 = 1'b1;
        drv(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drv(1, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk_cleared(0, "reset32");
        chk_cleared(1, "reset8");
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // add overflow at the positive limit
        run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, -1);
        // sub then slt back-to-back with start held through the done cycle
        issue(0, OP_SUB, 32'd5, 32'd5);
        @(negedge clk);
        issue(0, OP_SLT, 32'hFFFF_FFFD, 32'd2);
        @(negedge clk);
        set_start(0, 1'b0);
        @(negedge clk);
        // full-scale multiply with a stray start pulse while busy
        run_op(0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        // divide, then divide by zero
        run_op(0, OP_DIV, 32'd100, 32'd7, -1);
        run_op(0, OP_DIV, 32'd9, 32'd0, -1);
        run_op(0, OP_J, 32'd123, 32'd456, -1);
        run_op(0, OP_SUB, 32'h8000_0000, 32'd1, -1);

        // asynchronous reset in the middle of a multiply
        issue(0, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst0 = 1'b1;
        #1 chk_cleared(0, "async_reset");
        q0.delete();
        last[0] = zero_e();
        @(negedge clk);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        run_op(0, OP_ADD, 32'd2, 32'd3, -1);

        // narrow instance
        run_op(1, OP_MUL, 32'hFF, 32'h02, -1);
        run_op(1, OP_J, 32'h11, 32'h22, -1);
        run_op(1, OP_ADD, 32'h7F, 32'h01, -1);
        run_op(1, OP_DIV, 32'hC8, 32'h0D, -1);
        run_op(1, OP_DIV, 32'h2A, 32'h00, -1);

        // random traffic on both widths
        for (int i = 0; i < 60; i++) begin
            k  = (i % 3 == 2) ? 1 : 0;
            op = tbl[$urandom_range(0, 8)];
            if (op == 4'b0011) op = 4'($urandom);
            run_op(k, op, rnd_opnd(k), rnd_opnd(k), ($urandom_range(0, 3) == 0) ? 3 : -1);
        end

        repeat (3) @(negedge clk);
        chk("drain_q32", 32'(q0.size()), 32'd0);
        chk("drain_q8", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the single-cycle ALU.
- Keeps the 4-bit ALUcontrol encoding and adds signed overflow detection.
- Adds iterative unsigned multiply and divide with a start/busy/done handshake.
- Sits beside the datapath ALU; the controller stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when state is IDLE or DONE.
- ALUcontrol  input  4  operation code, sampled with start.
- a  input  WIDTH  operand A (signed for add/sub/slt; unsigned for mul/div), sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- result_lo  output  WIDTH  primary result; quotient for div; low product half for mul.
- result_hi  output  WIDTH  high product half for mul; remainder for div; 0 for all other ops.
- zero  output  1  result_lo == 0.
- overflow  output  1  signed overflow of add/sub.
- div_zero  output  1  div was issued with b == 0.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse: results valid.

Behaviour:
- Reset (async, any state, including mid-operation): all outputs 0, internal registers cleared, state IDLE. An in-flight operation is discarded.
- Opcodes:
  - 0010 add
  - 0110 sub
  - 0000 and
  - 0001 or
  - 0111 slt (signed; result 1 or 0)
  - 1000 mul (unsigned, 2*WIDTH product)
  - 1001 div (unsigned quotient and remainder)
  - 1111 j, and every unlisted code: no-op.
- States: IDLE, RUN, DONE.
- Accept edge: start=1 on a rising edge while in IDLE or DONE. a, b and ALUcontrol are latched on that edge. start is ignored while in RUN.
- Single-cycle ops (add, sub, and, or, slt, no-op):
  - Go directly to DONE; outputs update on the accept edge, so latency is 1 clock.
  - done=1 and busy=0 for that cycle.
- mul and div:
  - Go to RUN; busy=1 for exactly WIDTH cycles.
  - mul: shift-add, one bit per cycle.
  - div: restoring, one bit per cycle.
  - Then DONE for one cycle: outputs update, done=1, busy=0.
  - Total latency from accept edge to the done cycle is WIDTH+1 clocks.
- DONE -> IDLE on the next edge unless start=1, in which case it is a new accept. Back-to-back issue is allowed.
- Result outputs hold their value until the next completion; they never change while busy=1.
- No-op: result_lo, result_hi, zero and overflow keep their previous values; done still pulses.
- Flag rules:
  - overflow: add sets it when the operand signs match and the result sign differs. Sub sets it when the operand signs differ and the result sign differs from a. All other ops clear it.
  - zero: recomputed from the new result_lo at every completion except no-op.
  - div_zero: set only by div with b=0; cleared by every other completed op.
- Divide by zero still runs WIDTH cycles, then gives result_lo = all ones and result_hi = a.
- Widths: add/sub wrap modulo 2^WIDTH. mul is exact ({result_hi, result_lo} = a*b). For div, result_lo*b + result_hi = a and result_hi < b.
- The counter counts down from WIDTH; it must not wrap or underflow for any legal WIDTH.

Test Plan (WIDTH=32 unless noted):
- add 0x7FFFFFFF + 0x00000001 -> one clock later done=1, result_lo=0x80000000, overflow=1, zero=0, busy never high.
- sub 5-5, then slt -3 vs 2, issued back-to-back with start held in the DONE cycle -> first: result_lo=0, zero=1; second: result_lo=1; done pulses on consecutive cycles.
- mul 0xFFFFFFFF*0xFFFFFFFF -> busy=1 for 32 cycles, done on cycle 33, result_hi=0xFFFFFFFE, result_lo=0x00000001; start pulsed at cycle 10 has no effect.
- div 100/7 -> after 33 cycles result_lo=14, result_hi=2, div_zero=0; then div 9/0 -> result_lo=0xFFFFFFFF, result_hi=9, div_zero=1.
- Assert reset at cycle 15 of a mul -> all outputs 0 immediately (asynchronous), no done pulse; a following add 2+3 completes normally with result 5.
- WIDTH=8: mul 0xFF*0x02 -> busy 8 cycles, result_hi=0x01, result_lo=0xFE; issue opcode 1111 -> done pulses, results unchanged.
